text_cursor_ctrl: RTL and testbench
===================================

# text_cursor_ctrl

Terminal-style write sequencer for the 15x40 character plane. Accepts a byte stream (UART RX or keyboard decoder) over a valid/ready handshake, tracks a cursor, and turns each byte into the plane's write, scroll (push-up) or clear strobes. It is the only writer of the plane. The VGA reader keeps its own independent read port.

## Interface
- ROWS, 15, number of text rows
- COLS, 40, characters per row
- ROW_W, 4, row index width (ceil log2 ROWS)
- COL_W, 6, column index width (ceil log2 COLS)
- DATA_W, 8, character id width
- BLANK, 0, character id written for erase and scroll fill

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  source has a byte
- in_data  in  DATA_W  byte / character id
- in_ready  out  1  controller can accept a byte
- plane_data  out  DATA_W  data to plane write port
- plane_row  out  ROW_W  plane write row
- plane_col  out  COL_W  plane write column
- plane_we  out  1  plane write enable
- plane_push_up  out  1  plane scroll strobe (qualified by plane_we)
- plane_clear  out  1  plane clear strobe
- cursor_row  out  ROW_W  current cursor row
- cursor_col  out  COL_W  current cursor column

## Operation
- Byte decode on accept (in_valid && in_ready at posedge):
  - 0x0A (LF): cursor_col=0. If cursor_row<ROWS-1, row+1 with no plane op. Otherwise go to SCROLL.
  - 0x0D (CR): cursor_col=0, no plane op.
  - 0x0C (FF): go to CLEAR, then cursor=(0,0).
  - 0x08 (BS): see Configuration.
  - All other bytes: go to WRITE at the current cursor. Then advance col. At col==COLS-1, set col=0 and row+1. If row is already ROWS-1, col=0, row stays, and SCROLL follows.
- States:
  - IDLE: in_ready=(!reset). Cursor-only bytes complete here and remain in IDLE.
  - WRITE: plane_we=1, plane_data=byte, row/col=cursor before advance. Next state is SCROLL if wrap happened on the last row, else IDLE.
  - SCROLL: plane_we=1, plane_push_up=1, plane_row=ROWS-1, plane_col=0, plane_data=BLANK. This blanks the last-row column 0, which the plane's shift does not clear. Next state IDLE.
  - CLEAR: plane_clear=1, plane_we=0. Next state IDLE.
- All plane_* outputs are registered and are 0 in every state not listed above. They are held a full clock cycle, so the plane's negedge sample lands mid-cycle.
- Cursor always stays within 0..ROWS-1 and 0..COLS-1. Index arithmetic is in ROW_W/COL_W bits with explicit compares, never relying on natural wrap.

## Timing
- Reset:
  - In the reset cycle: state=CLEAR, cursor=(0,0), all outputs 0, in_ready=0.
  - First cycle after deassertion: plane_clear=1.
  - Next cycle: IDLE with in_ready=1.
- Printable byte accepted at edge N: plane_we high during cycle N+1, back in IDLE (in_ready=1) at N+2. Throughput is one printable byte per 2 cycles.
- Wrap on the last row: WRITE at N+1, SCROLL at N+2, IDLE at N+3.
- LF/CR: cursor updated at edge N, in_ready stays high, so back-to-back acceptance is possible.
- in_ready is low in WRITE, SCROLL and CLEAR. in_data is not sampled there.
- Reset asserted mid-WRITE or mid-SCROLL: strobes drop at the next edge, the partial operation is abandoned, and the normal reset sequence runs.

## Configuration
- TEXT_CTRL_BACKSPACE_EN defined:
  - 0x08 at col>0 moves col-1 and does a WRITE of BLANK there, with no advance.
  - At col 0, row>0 it moves to (row-1, COLS-1) and writes BLANK there.
  - At (0,0) it is a no-op that stays in IDLE.
- TEXT_CTRL_BACKSPACE_EN undefined: 0x08 is treated as a printable character id.

## Test plan
- Reset, then send 'A'(0x41) -> plane_clear pulse 1 cycle; write (0,0)=0x41; cursor=(0,1); in_ready low exactly 1 cycle.
- 40 bytes 0x30 from (0,0) -> writes at cols 0..39 of row 0; cursor=(1,0); no push_up.
- Cursor (14,39), send 0x42 -> WRITE (14,39)=0x42, then SCROLL cycle (we=1, push_up=1, row=14, col=0, data=0); cursor=(14,0).
- Cursor (14,5), send 0x0A -> single SCROLL cycle; cursor=(14,0). Cursor (3,5), send 0x0A then 0x0D -> no plane strobes; cursor=(4,0).
- Send 0x0C at (7,9) -> plane_clear 1 cycle, no we; cursor=(0,0).
- With TEXT_CTRL_BACKSPACE_EN: at (2,0) send 0x08 -> write (1,39)=0x00; cursor=(1,39). At (0,0) send 0x08 -> no strobe. Without the macro: 0x08 written as data.

Source files
------------

// File: rtl/text_cursor_ctrl_if.sv
// ---------------------------------------------------------------------------
// text_cursor_ctrl_if
// Byte-stream handshake between a character source (UART RX, keyboard
// decoder) and the text cursor controller. A byte moves on a rising clock
// edge where in_valid and in_ready are both high.
// ---------------------------------------------------------------------------
interface text_cursor_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  // Source side: offers bytes, watches for the controller's ready.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  // Controller side: samples bytes, advertises when it can take one.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/text_cursor_ctrl.sv
// ---------------------------------------------------------------------------
// text_cursor_ctrl
// Terminal-style write sequencer for the ROWS x COLS character plane.
// Accepts bytes over text_cursor_ctrl_if, tracks a cursor and turns each
// byte into plane write / scroll (push-up) / clear strobes. All plane
// strobes are registered and held one full clock so the plane's negedge
// sample lands mid-cycle.
//
// Build option: define TEXT_CTRL_BACKSPACE_EN to give 0x08 backspace
// behaviour (step back and blank). Without it 0x08 is an ordinary
// character id.
// ---------------------------------------------------------------------------
module text_cursor_ctrl #(
  parameter int                ROWS   = 15,
  parameter int                COLS   = 40,
  parameter int                ROW_W  = 4,
  parameter int                COL_W  = 6,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] BLANK  = {DATA_W{1'b0}}
) (
  input  logic                 clock,
  input  logic                 reset,
  text_cursor_ctrl_if.slave    in_bus,
  output logic [DATA_W-1:0]    plane_data,
  output logic [ROW_W-1:0]     plane_row,
  output logic [COL_W-1:0]     plane_col,
  output logic                 plane_we,
  output logic                 plane_push_up,
  output logic                 plane_clear,
  output logic [ROW_W-1:0]     cursor_row,
  output logic [COL_W-1:0]     cursor_col
);

  // FSM encoding kept as plain constants for compatibility with older tools.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WRITE  = 2'd1;
  localparam logic [1:0] S_SCROLL = 2'd2;
  localparam logic [1:0] S_CLEAR  = 2'd3;

  // Control bytes.
  localparam logic [DATA_W-1:0] CH_BS = DATA_W'(8'h08);
  localparam logic [DATA_W-1:0] CH_LF = DATA_W'(8'h0A);
  localparam logic [DATA_W-1:0] CH_FF = DATA_W'(8'h0C);
  localparam logic [DATA_W-1:0] CH_CR = DATA_W'(8'h0D);

  // Cursor limits, sized to the index widths so compares are exact.
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};
  localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

  // Architectural state.
  logic [1:0]        r_state;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic              r_scroll_pend;   // a wrap on the last row owes a SCROLL after WRITE
  logic [DATA_W-1:0] r_plane_data;
  logic [ROW_W-1:0]  r_plane_row;
  logic [COL_W-1:0]  r_plane_col;
  logic              r_plane_we;
  logic              r_plane_push_up;
  logic              r_plane_clear;

  // Next-state values.
  logic [1:0]        w_state;
  logic [ROW_W-1:0]  w_row;
  logic [COL_W-1:0]  w_col;
  logic              w_scroll_pend;
  logic [DATA_W-1:0] w_plane_data;
  logic [ROW_W-1:0]  w_plane_row;
  logic [COL_W-1:0]  w_plane_col;
  logic              w_plane_we;
  logic              w_plane_push_up;
  logic              w_plane_clear;
  logic              w_idle;
  logic              w_accept;

  assign w_idle          = (r_state == S_IDLE);
  // Ready is withheld combinationally while reset is high so no byte is
  // taken on the reset edge itself.
  assign in_bus.in_ready = w_idle && !reset;
  assign w_accept        = in_bus.in_valid && w_idle;

  // Decode the current state and accepted byte into cursor, FSM and strobe updates.
  always_comb begin
    w_state         = r_state;
    w_row           = r_row;
    w_col           = r_col;
    w_scroll_pend   = r_scroll_pend;
    w_plane_data    = {DATA_W{1'b0}};
    w_plane_row     = ROW_ZERO;
    w_plane_col     = COL_ZERO;
    w_plane_we      = 1'b0;
    w_plane_push_up = 1'b0;
    w_plane_clear   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (in_bus.in_data)
            CH_LF: begin
              w_col = COL_ZERO;
              if (r_row < ROW_LAST) begin
                w_row = r_row + ROW_ONE;
              end else begin
                // Already on the bottom row: scroll instead of moving down.
                w_state         = S_SCROLL;
                w_plane_we      = 1'b1;
                w_plane_push_up = 1'b1;
                w_plane_row     = ROW_LAST;
                w_plane_col     = COL_ZERO;
                w_plane_data    = BLANK;
              end
            end
            CH_CR: begin
              w_col = COL_ZERO;
            end
            CH_FF: begin
              w_state       = S_CLEAR;
              w_plane_clear = 1'b1;
              w_row         = ROW_ZERO;
              w_col         = COL_ZERO;
            end
`ifdef TEXT_CTRL_BACKSPACE_EN
            CH_BS: begin
              if (r_col != COL_ZERO) begin
                // Step left on the same row and blank that cell.
                w_col        = r_col - COL_ONE;
                w_state      = S_WRITE;
                w_plane_we   = 1'b1;
                w_plane_row  = r_row;
                w_plane_col  = r_col - COL_ONE;
                w_plane_data = BLANK;
              end else if (r_row != ROW_ZERO) begin
                // Step back to the end of the previous row and blank it.
                w_row        = r_row - ROW_ONE;
                w_col        = COL_LAST;
                w_state      = S_WRITE;
                w_plane_we   = 1'b1;
                w_plane_row  = r_row - ROW_ONE;
                w_plane_col  = COL_LAST;
                w_plane_data = BLANK;
              end else begin
                // Home position: nothing to erase.
                w_state = S_IDLE;
              end
            end
`endif
            default: begin
              // Printable: write at the cursor, then advance with wrap.
              w_state      = S_WRITE;
              w_plane_we   = 1'b1;
              w_plane_row  = r_row;
              w_plane_col  = r_col;
              w_plane_data = in_bus.in_data;
              if (r_col == COL_LAST) begin
                w_col = COL_ZERO;
                if (r_row == ROW_LAST) begin
                  w_scroll_pend = 1'b1;
                end else begin
                  w_row = r_row + ROW_ONE;
                end
              end else begin
                w_col = r_col + COL_ONE;
              end
            end
          endcase
        end else begin
          w_state = S_IDLE;
        end
      end

      S_WRITE: begin
        if (r_scroll_pend) begin
          w_state         = S_SCROLL;
          w_scroll_pend   = 1'b0;
          w_plane_we      = 1'b1;
          w_plane_push_up = 1'b1;
          w_plane_row     = ROW_LAST;
          w_plane_col     = COL_ZERO;
          w_plane_data    = BLANK;
        end else begin
          w_state = S_IDLE;
        end
      end

      S_SCROLL: begin
        w_state = S_IDLE;
      end

      S_CLEAR: begin
        // Entered from reset the strobe has not fired yet: fire it and stay.
        // Once it has been held for a cycle, return to IDLE.
        if (r_plane_clear) begin
          w_state = S_IDLE;
        end else begin
          w_plane_clear = 1'b1;
          w_state       = S_CLEAR;
        end
      end

      default: begin
        w_state = S_CLEAR;
      end
    endcase
  end

  // Register FSM, cursor and all plane strobes; reset abandons any operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= S_CLEAR;
      r_row           <= ROW_ZERO;
      r_col           <= COL_ZERO;
      r_scroll_pend   <= 1'b0;
      r_plane_data    <= {DATA_W{1'b0}};
      r_plane_row     <= ROW_ZERO;
      r_plane_col     <= COL_ZERO;
      r_plane_we      <= 1'b0;
      r_plane_push_up <= 1'b0;
      r_plane_clear   <= 1'b0;
    end else begin
      r_state         <= w_state;
      r_row           <= w_row;
      r_col           <= w_col;
      r_scroll_pend   <= w_scroll_pend;
      r_plane_data    <= w_plane_data;
      r_plane_row     <= w_plane_row;
      r_plane_col     <= w_plane_col;
      r_plane_we      <= w_plane_we;
      r_plane_push_up <= w_plane_push_up;
      r_plane_clear   <= w_plane_clear;
    end
  end

  assign plane_data    = r_plane_data;
  assign plane_row     = r_plane_row;
  assign plane_col     = r_plane_col;
  assign plane_we      = r_plane_we;
  assign plane_push_up = r_plane_push_up;
  assign plane_clear   = r_plane_clear;
  assign cursor_row    = r_row;
  assign cursor_col    = r_col;

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_text_cursor_ctrl
// Directed scenarios plus randomized byte stream for text_cursor_ctrl.
// The reference model keeps a cursor and, per accepted byte, the list of
// plane operations (one per cycle) that terminal semantics call for.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_text_cursor_ctrl;

  localparam int ROWS = 15;
  localparam int COLS = 40;

  localparam int OP_WRITE  = 0;
  localparam int OP_SCROLL = 1;
  localparam int OP_CLEAR  = 2;

  typedef struct {
    int kind;
    int row;
    int col;
    int data;
  } op_t;

  logic       clock;
  logic       reset;
  logic [7:0] plane_data;
  logic [3:0] plane_row;
  logic [5:0] plane_col;
  logic       plane_we;
  logic       plane_push_up;
  logic       plane_clear;
  logic [3:0] cursor_row;
  logic [5:0] cursor_col;

  text_cursor_ctrl_if #(.DATA_W(8)) in_bus ();

  text_cursor_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .in_bus        (in_bus),
    .plane_data    (plane_data),
    .plane_row     (plane_row),
    .plane_col     (plane_col),
    .plane_we      (plane_we),
    .plane_push_up (plane_push_up),
    .plane_clear   (plane_clear),
    .cursor_row    (cursor_row),
    .cursor_col    (cursor_col)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference cursor and pending plane operations.
  int  m_row = 0;
  int  m_col = 0;
  op_t ops[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pv(input int we, input int push, input int clr,
                                     input int row, input int col, input int data);
    return {11'd0, we[0], push[0], clr[0], row[3:0], col[5:0], data[7:0]};
  endfunction

  function automatic logic [31:0] dut_pv();
    return {11'd0, plane_we, plane_push_up, plane_clear, plane_row, plane_col, plane_data};
  endfunction

  function automatic logic [31:0] op_pv(input op_t o);
    if (o.kind == OP_WRITE)  return pv(1, 0, 0, o.row, o.col, o.data);
    if (o.kind == OP_SCROLL) return pv(1, 1, 0, ROWS - 1, 0, 0);
    return pv(0, 0, 1, 0, 0, 0);
  endfunction

  // Terminal semantics: update model cursor and queue the plane operations.
  task automatic model_byte(input int b);
    op_t o;
    ops.delete();
    if (b == 8'h0A) begin
      m_col = 0;
      if (m_row < ROWS - 1) m_row++;
      else begin o = '{OP_SCROLL, 0, 0, 0}; ops.push_back(o); end
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0C) begin
      o = '{OP_CLEAR, 0, 0, 0}; ops.push_back(o);
      m_row = 0; m_col = 0;
`ifdef TEXT_CTRL_BACKSPACE_EN
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        o = '{OP_WRITE, m_row, m_col, 0}; ops.push_back(o);
      end else if (m_row > 0) begin
        m_row--; m_col = COLS - 1;
        o = '{OP_WRITE, m_row, m_col, 0}; ops.push_back(o);
      end
`endif
    end else begin
      o = '{OP_WRITE, m_row, m_col, b}; ops.push_back(o);
      if (m_col == COLS - 1) begin
        m_col = 0;
        if (m_row == ROWS - 1) begin o = '{OP_SCROLL, 0, 0, 0}; ops.push_back(o); end
        else m_row++;
      end else m_col++;
    end
  endtask

  // Idle-state expectations at a negedge: no strobes, ready, model cursor.
  task automatic check_idle(input string tag);
    check_val({tag, "_strobes"}, dut_pv(), pv(0, 0, 0, 0, 0, 0));
    check_val({tag, "_ready"}, 32'(in_bus.in_ready), 32'd1);
    check_val({tag, "_cursor"}, {16'd0, 4'd0, cursor_row, 2'd0, cursor_col},
              {16'd0, 4'd0, 4'(m_row), 2'd0, 6'(m_col)});
  endtask

  // Wait (bounded) for ready at a negedge.
  task automatic wait_ready();
    int k = 0;
    while (in_bus.in_ready !== 1'b1 && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (in_bus.in_ready !== 1'b1) check_val("ready_timeout", 32'(in_bus.in_ready), 32'd1);
  endtask

  // Send one byte from a negedge and check every following cycle.
  task automatic send(input logic [7:0] b);
    wait_ready();
    in_bus.in_valid = 1'b1;
    in_bus.in_data  = b;
    @(posedge clock);
    model_byte(int'(b));
    @(negedge clock);
    in_bus.in_valid = 1'b0;
    in_bus.in_data  = 8'($urandom);
    foreach (ops[i]) begin
      check_val($sformatf("op%0d_b%02h", i, b), dut_pv(), op_pv(ops[i]));
      check_val($sformatf("op%0d_busy", i), 32'(in_bus.in_ready), 32'd0);
      @(negedge clock);
    end
    check_idle($sformatf("idle_b%02h", b));
  endtask

  task automatic goto_pos(input int r, input int c);
    send(8'h0C);
    for (int i = 0; i < r; i++) send(8'h0A);
    for (int i = 0; i < c; i++) send(8'h2E);
  endtask

  // Reset from a negedge; strobes must drop at the next edge, then the
  // clear pulse and return to IDLE follow deassertion.
  task automatic do_reset();
    reset = 1'b1;
    in_bus.in_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_val("rst_strobes", dut_pv(), pv(0, 0, 0, 0, 0, 0));
    check_val("rst_ready", 32'(in_bus.in_ready), 32'd0);
    check_val("rst_cursor", {26'd0, cursor_row, cursor_col[1:0]} | 32'(cursor_col), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    m_row = 0; m_col = 0;
    @(negedge clock);
    check_val("rst_clear_pulse", dut_pv(), pv(0, 0, 1, 0, 0, 0));
    check_val("rst_clear_busy", 32'(in_bus.in_ready), 32'd0);
    @(negedge clock);
    check_idle("rst_idle");
  endtask

  initial begin
    reset = 1'b1;
    in_bus.in_valid = 1'b0;
    in_bus.in_data  = 8'h00;
    @(negedge clock);
    do_reset();

    // First printable byte after reset.
    send(8'h41);

    // Full row of '0' from home.
    send(8'h0C);
    for (int i = 0; i < COLS; i++) send(8'h30);

    // Wrap on the last row.
    goto_pos(ROWS - 1, COLS - 1);
    send(8'h42);

    // LF on the last row.
    goto_pos(ROWS - 1, 5);
    send(8'h0A);

    // LF then CR back to back at (3,5): no strobes, ready stays high.
    goto_pos(3, 5);
    wait_ready();
    in_bus.in_valid = 1'b1;
    in_bus.in_data  = 8'h0A;
    @(posedge clock);
    model_byte(8'h0A);
    @(negedge clock);
    check_idle("b2b_lf");
    in_bus.in_data = 8'h0D;
    @(posedge clock);
    model_byte(8'h0D);
    @(negedge clock);
    in_bus.in_valid = 1'b0;
    check_idle("b2b_cr");
    check_val("b2b_pos", 32'(m_row * 64 + m_col), 32'(4 * 64 + 0));

    // Form feed mid-screen.
    goto_pos(7, 9);
    send(8'h0C);

    // Backspace cases (printable id when the option is off).
    goto_pos(2, 0);
    send(8'h08);
    send(8'h0C);
    send(8'h08);

    // Reset during WRITE and during SCROLL.
    goto_pos(1, 1);
    in_bus.in_valid = 1'b1; in_bus.in_data = 8'h55;
    @(posedge clock);
    @(negedge clock);
    in_bus.in_valid = 1'b0;
    do_reset();
    goto_pos(ROWS - 1, COLS - 1);
    in_bus.in_valid = 1'b1; in_bus.in_data = 8'h66;
    @(posedge clock);
    @(negedge clock);
    in_bus.in_valid = 1'b0;
    @(negedge clock);
    do_reset();

    // Randomized stream weighted towards printable bytes.
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [7:0] b;
      r = int'($urandom_range(0, 99));
      if (r < 10)      b = 8'h0A;
      else if (r < 14) b = 8'h0D;
      else if (r < 16) b = 8'h0C;
      else if (r < 24) b = 8'h08;
      else             b = 8'($urandom_range(0, 255));
      send(b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
